// File: rtl/sma_filter_pkg.sv
// Shared constants and helper functions for the streaming moving-average filter.
// The optional warm-up gate is enabled by defining SMA_FILTER_WARMUP_GATE_EN.
package sma_filter_pkg;

  // log2 of a power of two. Non-powers of two are caught by params_ok().
  function automatic int log2_pow2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The running sum needs log2(N) extra bits, so it can never overflow.
  function automatic int sum_width(input int w, input int n);
    return w + log2_pow2(n);
  endfunction

  // Legal parameter set: width >= 1, N >= 2, N a power of two.
  function automatic bit params_ok(input int w, input int n);
    return (w >= 1) && (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sma_filter_sample_buf.sv
// N-entry circular sample buffer. The entry at the write pointer is the oldest
// sample, which is the one about to be overwritten; it is exposed combinationally.
module sma_filter_sample_buf #(
  parameter int DATA_INPUT_WIDTH      = 16,
  parameter int NUM_SAMPLES_TO_FILTER = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [DATA_INPUT_WIDTH-1:0] wr_data,
  output logic [DATA_INPUT_WIDTH-1:0] oldest
);
  import sma_filter_pkg::*;

  localparam int W  = DATA_INPUT_WIDTH;
  localparam int N  = NUM_SAMPLES_TO_FILTER;
  localparam int PW = log2_pow2(N);

  logic [W-1:0]  mem_q [N];
  logic [PW-1:0] wr_ptr_q;

  assign oldest = mem_q[wr_ptr_q];

  // Store the accepted sample over the oldest one; the pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q        <= wr_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/sma_filter.sv
// Streaming simple-moving-average filter: running sum over the last N samples,
// floor mean registered one cycle after each accepted sample.
// Define SMA_FILTER_WARMUP_GATE_EN to suppress out_data_valid until N samples
// have been accepted since reset.
module sma_filter #(
  parameter int DATA_INPUT_WIDTH      = 16,
  parameter int NUM_SAMPLES_TO_FILTER = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_INPUT_WIDTH-1:0] in_data,
  input  logic                        in_data_valid,
  output logic [DATA_INPUT_WIDTH-1:0] out_data,
  output logic                        out_data_valid
);
  import sma_filter_pkg::*;

  localparam int W     = DATA_INPUT_WIDTH;
  localparam int N     = NUM_SAMPLES_TO_FILTER;
  localparam int LOG2N = log2_pow2(N);
  localparam int SW    = sum_width(W, N);

  if (!params_ok(W, N)) begin : g_param_check
    $fatal(1, "sma_filter: width must be >= 1 and N a power of two >= 2");
  end

  logic [W-1:0]  oldest;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_next;
  logic [W-1:0]  mean;
  logic          strobe_en;

  sma_filter_sample_buf #(
    .DATA_INPUT_WIDTH      (W),
    .NUM_SAMPLES_TO_FILTER (N)
  ) u_sample_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (in_data_valid),
    .wr_data (in_data),
    .oldest  (oldest)
  );

  // Oldest entry is always part of sum_q, so the subtraction cannot underflow.
  assign sum_next = sum_q + SW'(in_data) - SW'(oldest);
  assign mean     = sum_next[SW-1:LOG2N];

  // Running sum of the window contents.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_q <= '0;
    end else if (in_data_valid) begin
      sum_q <= sum_next;
    end
  end

`ifdef SMA_FILTER_WARMUP_GATE_EN
  localparam int             FW        = LOG2N + 1;
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_LAST = FW'(N - 1);

  logic [FW-1:0] fill_q;

  // Saturating count of accepted samples since reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fill_q <= '0;
    end else if (in_data_valid && (fill_q != FILL_FULL)) begin
      fill_q <= fill_q + FW'(1);
    end
  end

  // The sample arriving while fill_q == N-1 is the N-th, so it may strobe.
  assign strobe_en = (fill_q >= FILL_LAST);
`else
  assign strobe_en = 1'b1;
`endif

  // Output registers: mean updates on every accepted sample, strobe is one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data       <= '0;
      out_data_valid <= 1'b0;
    end else begin
      out_data_valid <= in_data_valid && strobe_en;
      if (in_data_valid) out_data <= mean;
    end
  end

endmodule

// File: tb/tb_sma_filter.sv
// Self-checking bench for sma_filter (N=4, 16-bit). Reference model keeps the
// sample history in a queue and averages it with plain arithmetic.
module tb_sma_filter;
  localparam int W = 16;
  localparam int N = 4;

  logic         clk;
  logic         rstn;
  logic [W-1:0] in_data;
  logic         in_data_valid;
  logic [W-1:0] out_data;
  logic         out_data_valid;

  int checks;
  int failures;

  // reference model state
  int unsigned hist[$];
  int unsigned accepted;
  int unsigned exp_data;
  bit          exp_valid;

  sma_filter #(
    .DATA_INPUT_WIDTH      (W),
    .NUM_SAMPLES_TO_FILTER (N)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_data        (in_data),
    .in_data_valid  (in_data_valid),
    .out_data       (out_data),
    .out_data_valid (out_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, req, req, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input int unsigned d);
    int unsigned s;
    if (!r) begin
      hist.delete();
      accepted  = 0;
      exp_data  = 0;
      exp_valid = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      exp_data = s / N;
      accepted++;
`ifdef SMA_FILTER_WARMUP_GATE_EN
      exp_valid = (accepted >= N);
`else
      exp_valid = 1'b1;
`endif
    end else begin
      exp_valid = 1'b0;
    end
  endfunction

  // Apply one cycle of stimulus, advance the model on the edge, check #1 later.
  task automatic cycle(input bit r, input bit v, input int unsigned d);
    rstn          = r;
    in_data_valid = v;
    in_data       = W'(d);
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check_val("out_data", 32'(out_data), exp_data);
    check_val("out_valid", 32'(out_data_valid), 32'(exp_valid));
  endtask

  int strobes;
  int exp_strobes;
  int gap_exp[4] = '{1, 3, 6, 10};
  int gap_idx;

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0; in_data_valid = 1'b0; in_data = '0;

    // reset then idle: outputs stay at zero
    cycle(0, 0, 0);
    cycle(0, 1, 16'h1234);
    check_val("reset_priority", 32'(out_data_valid), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      check_val("idle_data", 32'(out_data), 0);
      check_val("idle_valid", 32'(out_data_valid), 0);
    end

    // back-to-back ramp 0..255
    cycle(0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1, 1, i);
      if (out_data_valid) strobes++;
      check_val("ramp_formula", 32'(out_data), (i < 3) ? 0 : i - 2);
    end
    check_val("ramp_last", 32'(out_data), 253);
`ifdef SMA_FILTER_WARMUP_GATE_EN
    exp_strobes = 253;
`else
    exp_strobes = 256;
`endif
    check_val("ramp_strobes", 32'(strobes), 32'(exp_strobes));
    cycle(1, 0, 0);
    check_val("ramp_hold", 32'(out_data), 253);

    // first sample 8 -> 2
    cycle(0, 0, 0);
    cycle(1, 1, 8);
    check_val("first_8", 32'(out_data), 2);

    // full-scale samples
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 16'hFFFF);
      check_val("max", 32'(out_data), 32'(16'h3FFF + i * 16'h4000));
    end

    // gapped valid: 4, idle, 8, idle x3, 12, 16
    cycle(0, 0, 0);
    gap_idx = 0;
    for (int i = 0; i < 8; i++) begin
      bit v;
      v = (i == 0) || (i == 2) || (i == 6) || (i == 7);
      cycle(1, v, v ? 4 * (gap_idx + 1) : 16'hBEEF);
      if (v) begin
        check_val("gap_data", 32'(out_data), 32'(gap_exp[gap_idx]));
        gap_idx++;
      end else begin
        check_val("gap_idle_valid", 32'(out_data_valid), 0);
      end
    end

    // reset mid-stream discards the window
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 100);
    check_val("pre_reset", 32'(out_data), 100);
    cycle(0, 0, 0);
    cycle(1, 1, 4);
    check_val("post_reset", 32'(out_data), 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 9) < 7);
      cycle(r, v, $urandom_range(0, 65535));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
